// File: rtl/rfid_wb_sequencer_if.sv
// ---------------------------------------------------------------------------
// rfid_wb_sequencer_if
// Wishbone bus bundle between the RFID command sequencer (master) and the
// front-end peripheral fabric (slave).
//
// Signals:
//   cyc_o      master -> slave  bus cycle
//   stb_o      master -> slave  one-hot strobe target (01 / 10)
//   adr_o      master -> slave  3-bit register address
//   we_o       master -> slave  write enable
//   dat_o      master -> slave  8-bit write data
//   dat_i_sel  master -> slave  read-data mux select
//   dat_i      slave  -> master 1-bit read data
//   ack_i      slave  -> master acknowledge
//   inta_i     slave  -> master peripheral interrupt
// ---------------------------------------------------------------------------
interface rfid_wb_sequencer_if;
    logic       cyc_o;
    logic [1:0] stb_o;
    logic [2:0] adr_o;
    logic       we_o;
    logic [7:0] dat_o;
    logic       dat_i_sel;
    logic       dat_i;
    logic       ack_i;
    logic       inta_i;

    modport master (
        output cyc_o, stb_o, adr_o, we_o, dat_o, dat_i_sel,
        input  dat_i, ack_i, inta_i
    );

    modport slave (
        input  cyc_o, stb_o, adr_o, we_o, dat_o, dat_i_sel,
        output dat_i, ack_i, inta_i
    );
endinterface

// File: rtl/rfid_wb_sequencer.sv
// ---------------------------------------------------------------------------
// rfid_wb_sequencer
// Wishbone-master command sequencer for the RFID front end. A host loads a
// script of 16-bit command words, pulses start_i, and the sequencer issues
// one bus cycle per command, optionally waiting for a peripheral interrupt,
// capturing read bits and flagging bus timeouts.
//
// Command word: [15] LAST  [14] WAIT_INT  [13] DAT_I_SEL  [12] STRB_TRGT
//               [11:9] ADR [8] WE         [7:0] DATA
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   ld_we_i/ld_addr_i/ld_data_i  command memory write port (IDLE only)
//   start_i                 run script from entry 0
//   stop_i                  stop at the next command fetch
//   cs_cfg_i                chip-select pattern captured at start
//   wb                      Wishbone master bundle (rfid_wb_sequencer_if)
//   spi_cs                  SPI chip selects
//   busy_o, done_o, err_o   run status, completion pulse, sticky timeout
//   rx_data_o               shift register of captured read bits
//   debug_state             {state[2:0], pc[4:0]}
//
// Build option: define RFID_SEQ_LOOP_EN to make the script repeat until
// stop_i or a timeout; done_o then pulses once per pass.
//
// state | meaning
// IDLE  | waiting for start_i, load port open
// FETCH | latch mem[pc] into the command register, reload timer
// REQ   | bus cycle active until ack_i or timeout
// WAITI | command waits for inta_i or timeout
// DONE  | one-cycle completion, done_o high
// ---------------------------------------------------------------------------
module rfid_wb_sequencer #(
    parameter int  DEPTH   = 16,
    parameter int  TIMEOUT = 255,
    parameter int  CS_W    = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ld_we_i,
    input  logic [AW-1:0]       ld_addr_i,
    input  logic [15:0]         ld_data_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [CS_W-1:0]     cs_cfg_i,
    rfid_wb_sequencer_if.master wb,
    output logic [CS_W-1:0]     spi_cs,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [7:0]          rx_data_o,
    output logic [7:0]          debug_state
);

`ifdef RFID_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam int B_LAST = 15;
    localparam int B_WAIT = 14;
    localparam int B_SEL  = 13;
    localparam int B_STRB = 12;
    localparam int B_WE   = 8;

    // Timer counts down from TIMEOUT-1; a wait that is still pending when it
    // reads zero has used its full TIMEOUT cycles.
    localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   TMO_LOAD = TW'(TIMEOUT - 1);
    localparam logic [AW-1:0]   PC_LAST  = AW'(DEPTH - 1);
    localparam logic [CS_W-1:0] CS_RST   = CS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_REQ   = 3'd2,
        S_WAITI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [15:0]     mem [DEPTH];
    logic [15:0]     cmd_q;
    logic [AW-1:0]   pc_q;
    logic [TW-1:0]   tmo_q;
    logic [4:0]      pc_dbg;

    logic            ack_ev;
    logic            int_ev;
    logic            adv_ev;
    logic            tmo_ev;
    logic            last_cmd;

    // ack/inta in the same cycle the timer expires takes priority.
    assign ack_ev   = (state_q == S_REQ) && wb.ack_i;
    assign int_ev   = (state_q == S_WAITI) && wb.inta_i;
    assign adv_ev   = (ack_ev && !cmd_q[B_WAIT]) || int_ev;
    assign tmo_ev   = (tmo_q == '0) &&
                      (((state_q == S_REQ) && !wb.ack_i) ||
                       ((state_q == S_WAITI) && !wb.inta_i));
    // The final entry behaves as LAST so pc never wraps past DEPTH-1.
    assign last_cmd = cmd_q[B_LAST] || (pc_q == PC_LAST);

    // Command memory has no reset; writes only land while idle.
    always_ff @(posedge clk_i) begin
        if (ld_we_i && (state_q == S_IDLE)) begin
            mem[ld_addr_i] <= ld_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = stop_i ? S_IDLE : S_REQ;
            end
            S_REQ, S_WAITI: begin
                if (adv_ev) begin
                    if (!last_cmd)    state_d = S_FETCH;
                    else if (LOOP_EN) state_d = S_FETCH;
                    else              state_d = S_DONE;
                end else if (ack_ev) begin
                    state_d = S_WAITI;
                end else if (tmo_ev) begin
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wb.cyc_o     = 1'b0;
        wb.stb_o     = 2'b00;
        wb.adr_o     = cmd_q[11:9];
        wb.we_o      = cmd_q[B_WE];
        wb.dat_o     = cmd_q[7:0];
        wb.dat_i_sel = cmd_q[B_SEL];
        if (state_q == S_REQ) begin
            wb.cyc_o = 1'b1;
            wb.stb_o = cmd_q[B_STRB] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q      <= '0;
            cmd_q     <= '0;
            tmo_q     <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            rx_data_o <= '0;
            spi_cs    <= CS_RST;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pc_q      <= '0;
                        err_o     <= 1'b0;
                        rx_data_o <= '0;
                        spi_cs    <= cs_cfg_i;
                        busy_o    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    cmd_q <= mem[pc_q];
                    tmo_q <= TMO_LOAD;
                    if (stop_i) busy_o <= 1'b0;
                end
                S_REQ, S_WAITI: begin
                    if (tmo_q != '0) tmo_q <= tmo_q - TW'(1);
                    if (ack_ev && !cmd_q[B_WE]) begin
                        rx_data_o <= {rx_data_o[6:0], wb.dat_i};
                    end
                    if (adv_ev) begin
                        if (last_cmd) begin
                            done_o <= 1'b1;
                            if (LOOP_EN) pc_q <= '0;
                        end else begin
                            pc_q <= pc_q + AW'(1);
                        end
                    end
                    if (tmo_ev) begin
                        err_o  <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pc_dbg      = 5'(pc_q);
    assign debug_state = {state_q, pc_dbg};

endmodule

// File: tb/tb_rfid_wb_sequencer.sv
`timescale 1ns/1ps
module tb_rfid_wb_sequencer;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int CS_W    = 2;
    localparam int AW      = 3;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b0;
    logic            ld_we_i = 1'b0;
    logic [AW-1:0]   ld_addr_i = '0;
    logic [15:0]     ld_data_i = '0;
    logic            start_i = 1'b0;
    logic            stop_i = 1'b0;
    logic [CS_W-1:0] cs_cfg_i = '0;
    logic [CS_W-1:0] spi_cs;
    logic            busy_o;
    logic            done_o;
    logic            err_o;
    logic [7:0]      rx_data_o;
    logic [7:0]      debug_state;

    rfid_wb_sequencer_if bus ();

    rfid_wb_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CS_W(CS_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ld_we_i     (ld_we_i),
        .ld_addr_i   (ld_addr_i),
        .ld_data_i   (ld_data_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .cs_cfg_i    (cs_cfg_i),
        .wb          (bus.master),
        .spi_cs      (spi_cs),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .rx_data_o   (rx_data_o),
        .debug_state (debug_state)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] stb;
        logic       sel;
        logic [2:0] adr;
        logic       we;
        logic [7:0] dat;
        logic       din;
        int         cyc_no;
    } txn_t;

    txn_t        log_q[$];
    int          ws_q[$];
    logic        din_q[$];
    logic [15:0] mem_m [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cycle_no = 0;
    int          done_cnt = 0;
    int          cyc_cnt = 0;
    bit          hold_ack = 1'b0;
    int          r_wcnt = 0;
    int          r_tgt = -1;

    always @(posedge clk_i) cycle_no <= cycle_no + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wishbone slave: acks after a planned or random number of wait states,
    // logs every acknowledged transfer and counts done_o / cyc_o cycles.
    initial begin
        txn_t t;
        bus.ack_i  = 1'b0;
        bus.dat_i  = 1'b0;
        bus.inta_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (bus.cyc_o) cyc_cnt++;
            if (done_o) done_cnt++;
            if (bus.ack_i) begin
                bus.ack_i = 1'b0;
            end else if (bus.cyc_o && !hold_ack) begin
                if (r_tgt < 0) r_tgt = (ws_q.size() > 0) ? ws_q.pop_front() : int'($urandom_range(0, 3));
                if (r_wcnt == r_tgt) begin
                    bus.dat_i = (din_q.size() > 0) ? din_q.pop_front() : 1'($urandom_range(0, 1));
                    bus.ack_i = 1'b1;
                    t.stb = bus.stb_o; t.sel = bus.dat_i_sel; t.adr = bus.adr_o;
                    t.we  = bus.we_o;  t.dat = bus.dat_o;     t.din = bus.dat_i;
                    t.cyc_no = cycle_no;
                    log_q.push_back(t);
                    r_wcnt = 0;
                    r_tgt  = -1;
                end else begin
                    r_wcnt++;
                end
            end else if (!bus.cyc_o) begin
                r_wcnt = 0;
                r_tgt  = -1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // Expected bus view of a command word.
    function automatic logic [14:0] bus_view(input logic [15:0] w);
        return {(w[12] ? 2'b10 : 2'b01), w[13], w[11:9], w[8], w[7:0]};
    endfunction

    task automatic load(input int a, input logic [15:0] d, input bit track);
        @(posedge clk_i); #1;
        ld_we_i = 1'b1; ld_addr_i = 3'(a); ld_data_i = d;
        if (track) mem_m[a] = d;
        @(posedge clk_i); #1;
        ld_we_i = 1'b0;
    endtask

    task automatic start_run(input logic [1:0] cs);
        log_q.delete();
        done_cnt = 0;
        cyc_cnt  = 0;
        cs_cfg_i = cs;
        @(posedge clk_i); #1 start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 2000) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    // Reference: walk the script from entry 0 until LAST or the last entry.
    task automatic check_run(input string tag, input logic [1:0] cs);
        logic [15:0] exp_q[$];
        logic [7:0]  rx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(mem_m[i]);
            if (mem_m[i][15]) break;
        end
        chk({tag, "_ntxn"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk({tag, "_txn"}, {log_q[i].stb, log_q[i].sel, log_q[i].adr, log_q[i].we, log_q[i].dat},
                bus_view(exp_q[i]));
            if (!exp_q[i][8]) rx = {rx[6:0], log_q[i].din};
        end
        chk({tag, "_rx"}, rx_data_o, rx);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_cs"}, spi_cs, cs);
    endtask

    initial begin
        int          n;
        int          ack_c;
        logic [15:0] w;
        logic [1:0]  cs;

        repeat (3) @(negedge clk_i);
        chk("rst_cyc", bus.cyc_o, 0);
        chk("rst_stb", bus.stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_rx", rx_data_o, 0);
        chk("rst_dbg", debug_state, 0);
        chk("rst_cs", spi_cs, 2'b01);
        chk("rst_bus", {bus.adr_o, bus.we_o, bus.dat_o, bus.dat_i_sel}, 0);
        rst_i = 1'b1;

`ifndef RFID_SEQ_LOOP_EN
        // Single write command with LAST.
        load(0, 16'h81AA, 1);
        ws_q.push_back(0);
        start_run(2'b10);
        @(negedge clk_i);
        chk("t1_fetch_cyc", bus.cyc_o, 0);
        chk("t1_fetch_busy", busy_o, 1);
        @(negedge clk_i);
        chk("t1_cyc", bus.cyc_o, 1);
        chk("t1_stb", bus.stb_o, 2'b01);
        chk("t1_adr", bus.adr_o, 0);
        chk("t1_we", bus.we_o, 1);
        chk("t1_dat", bus.dat_o, 8'hAA);
        chk("t1_cs", spi_cs, 2'b10);
        @(negedge clk_i);
        chk("t1_cyc_off", bus.cyc_o, 0);
        chk("t1_done_hi", done_o, 1);
        @(negedge clk_i);
        chk("t1_done_lo", done_o, 0);
        chk("t1_busy_lo", busy_o, 0);
        check_run("t1", 2'b10);

        // Write, read(1), read(0) with 0/2/5 wait states.
        load(0, 16'h0311, 1);
        load(1, 16'h3455, 1);
        load(2, 16'h860F, 1);
        ws_q = '{0, 2, 5};
        din_q = '{1'b0, 1'b1, 1'b0};
        start_run(2'b01);
        wait_idle("t2");
        check_run("t2", 2'b01);
        chk("t2_rx_const", rx_data_o, 8'h02);
        if (log_q.size() == 3) begin
            chk("t2_gap1", log_q[1].cyc_no - log_q[0].cyc_no, 4);
            chk("t2_gap2", log_q[2].cyc_no - log_q[1].cyc_no, 7);
        end
        chk("t2_cyc_cycles", cyc_cnt, 10);

        // Random scripts, some without LAST to exercise the final entry.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                w = 16'($urandom) & 16'h3FFF;
                if ((r % 3) != 2 && i == n - 1) w[15] = 1'b1;
                load(i, w, 1);
            end
            cs = 2'($urandom_range(0, 3));
            start_run(cs);
            wait_idle("t3");
            check_run("t3", cs);
        end

        // WAIT_INT command, interrupt 10 cycles after the ack.
        load(0, 16'h493C, 1);
        load(1, 16'h8BC3, 1);
        ws_q = '{0, 0};
        start_run(2'b11);
        n = 0;
        while (log_q.size() < 1 && n < 100) begin @(negedge clk_i); n++; end
        chk("t4_first_ack", log_q.size(), 1);
        ack_c = (log_q.size() > 0) ? log_q[0].cyc_no : cycle_no;
        while (cycle_no < ack_c + 10 && n < 200) begin @(negedge clk_i); n++; end
        chk("t4_waiting_ntxn", log_q.size(), 1);
        chk("t4_waiting_cyc", bus.cyc_o, 0);
        chk("t4_waiting_busy", busy_o, 1);
        bus.inta_i = 1'b1;
        @(negedge clk_i);
        bus.inta_i = 1'b0;
        chk("t4_fetch_cyc", bus.cyc_o, 0);
        @(negedge clk_i);
        chk("t4_req_cyc", bus.cyc_o, 1);
        chk("t4_req_adr", bus.adr_o, 3'd5);
        wait_idle("t4");
        check_run("t4", 2'b11);

        // Ack withheld: timeout after exactly TIMEOUT request cycles.
        load(0, 16'h81AA, 1);
        hold_ack = 1'b1;
        start_run(2'b01);
        wait_idle("t5");
        chk("t5_req_cycles", cyc_cnt, TIMEOUT);
        chk("t5_err", err_o, 1);
        chk("t5_done", done_cnt, 0);
        chk("t5_cyc", bus.cyc_o, 0);
        hold_ack = 1'b0;
        start_run(2'b01);
        @(negedge clk_i);
        chk("t5_err_clr", err_o, 0);
        wait_idle("t5b");
        check_run("t5b", 2'b01);

        // Reset in the middle of a request drops the bus immediately.
        hold_ack = 1'b1;
        start_run(2'b10);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("t6_pre_cyc", bus.cyc_o, 1);
        #1 rst_i = 1'b0;
        #1;
        chk("t6_rst_cyc", bus.cyc_o, 0);
        chk("t6_rst_stb", bus.stb_o, 0);
        chk("t6_rst_busy", busy_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        hold_ack = 1'b0;
        start_run(2'b10);
        wait_idle("t6_keep");
        check_run("t6_keep", 2'b10);

        // Load while busy is dropped; re-run shows the original script.
        load(0, 16'h0311, 1);
        load(1, 16'h860F, 1);
        ws_q = '{4, 4};
        start_run(2'b01);
        load(0, 16'hFFFF, 0);
        wait_idle("t6a");
        check_run("t6a", 2'b01);
        start_run(2'b01);
        wait_idle("t6b");
        check_run("t6b", 2'b01);

        // stop_i ends the run at the next fetch without done_o.
        load(0, 16'h0311, 1);
        load(1, 16'h3455, 1);
        load(2, 16'h860F, 1);
        ws_q = '{2};
        start_run(2'b01);
        n = 0;
        while (log_q.size() < 1 && n < 100) begin @(negedge clk_i); n++; end
        stop_i = 1'b1;
        wait_idle("t7");
        stop_i = 1'b0;
        chk("t7_ntxn", log_q.size(), 1);
        chk("t7_done", done_cnt, 0);
        chk("t7_err", err_o, 0);
`else
        // Repeating two-command script, stopped after a few passes.
        load(0, 16'h0311, 1);
        load(1, 16'h860F, 1);
        start_run(2'b01);
        n = 0;
        while (done_cnt < 3 && n < 500) begin @(negedge clk_i); n++; end
        chk("loop_passes", done_cnt >= 3, 1);
        chk("loop_busy", busy_o, 1);
        stop_i = 1'b1;
        wait_idle("loop_stop");
        stop_i = 1'b0;
        n = 0;
        foreach (log_q[i]) if (log_q[i].adr == 3'd3) n++;
        chk("loop_done_per_pass", done_cnt, n);
        chk("loop_err", err_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
